// File: rtl/pe_array_wbuf_rd_sched.sv
// Weight-buffer read scheduler for the weight-stationary PE array: walks N addresses x P passes,
// then drains the array pipeline so every request's partial sum has left the last row before done.
module pe_array_wbuf_rd_sched #(
   parameter int WBUF_READ_ADDR_WIDTH = 8,
   parameter int LOOP_CNT_WIDTH       = 8,
   parameter int ARRAY_M              = 32,
   parameter int WBUF_READ_LATENCY_B  = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [WBUF_READ_ADDR_WIDTH-1:0] cfg_base_addr,
   input  logic [WBUF_READ_ADDR_WIDTH-1:0] cfg_num_addr,
   input  logic [LOOP_CNT_WIDTH-1:0]       cfg_num_pass,
   input  logic                            stall,
   output logic                            busy,
   output logic                            done,
   output logic                            read_req_w_mem,
   output logic [WBUF_READ_ADDR_WIDTH-1:0] r_addr_w_mem,
   output logic                            act_valid,
   output logic                            out_valid
);

   localparam int AW = WBUF_READ_ADDR_WIDTH;
   localparam int LW = LOOP_CNT_WIDTH;
   localparam int D  = WBUF_READ_LATENCY_B + ARRAY_M;
   localparam int DW = $clog2(D + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [AW-1:0] A_ONE = AW'(1);
   localparam logic [LW-1:0] L_ONE = LW'(1);
   localparam logic [DW-1:0] D_ONE = DW'(1);
   localparam logic [DW-1:0] D_END = DW'(D - 1);

   logic [1:0]    state;
   logic [AW-1:0] base_r;
   logic [AW-1:0] num_addr_r;
   logic [LW-1:0] num_pass_r;
   logic [AW-1:0] addr_cnt;
   logic [LW-1:0] pass_cnt;
   logic [DW-1:0] drain_cnt;
   logic [D-1:0]  vline;

   logic issue;
   logic last_addr;
   logic last_pass;

   assign issue     = (state == S_RUN) && !stall;
   assign last_addr = (addr_cnt == num_addr_r - A_ONE);
   assign last_pass = (pass_cnt == num_pass_r - L_ONE);

   assign busy           = (state != S_IDLE);
   assign done           = (state == S_DONE);
   assign read_req_w_mem = issue;
   // Counters hold during stall, so the address holds with them.
   assign r_addr_w_mem   = base_r + addr_cnt;
   assign act_valid      = vline[WBUF_READ_LATENCY_B-1];
   assign out_valid      = vline[D-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         base_r     <= '0;
         num_addr_r <= '0;
         num_pass_r <= '0;
         addr_cnt   <= '0;
         pass_cnt   <= '0;
         drain_cnt  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  if ((cfg_num_addr != '0) && (cfg_num_pass != '0)) begin
                     base_r     <= cfg_base_addr;
                     num_addr_r <= cfg_num_addr;
                     num_pass_r <= cfg_num_pass;
                     addr_cnt   <= '0;
                     pass_cnt   <= '0;
                     state      <= S_RUN;
                  end else begin
                     state <= S_DONE;
                  end
               end
            end
            S_RUN: begin
               if (issue) begin
                  if (last_addr) begin
                     addr_cnt <= '0;
                     pass_cnt <= pass_cnt + L_ONE;
                     if (last_pass) begin
                        drain_cnt <= '0;
                        state     <= S_DRAIN;
                     end
                  end else begin
                     addr_cnt <= addr_cnt + A_ONE;
                  end
               end
            end
            S_DRAIN: begin
               // D cycles is exactly the depth of the valid line, so the last out_valid has fired.
               if (drain_cnt == D_END) begin
                  state <= S_DONE;
               end else begin
                  drain_cnt <= drain_cnt + D_ONE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vline <= '0;
      end else begin
         vline <= {vline[D-2:0], read_req_w_mem};
      end
   end

endmodule

// File: doc/pe_array_wbuf_rd_sched.md
Name: pe_array_wbuf_rd_sched

Overview:
- Read scheduler for the weight-stationary systolic PE array.
- Drives the read request and read address into the row-0 PEs' weight buffers; the PE chain forwards these down the array.
- Issues activation-valid aligned to weight-buffer read latency, and flags when partial sums leave the last PE row.
- Sequences one configured tile (N addresses x P passes) per start/done handshake, with stall support from the activation feeder.

Parameters:
- WBUF_READ_ADDR_WIDTH, 8, width of the weight-buffer read address.
- LOOP_CNT_WIDTH, 8, width of the pass counter and cfg_num_pass.
- ARRAY_M, 32, number of PE rows; each row registers sum_out once.
- WBUF_READ_LATENCY_B, 1, cycles from read request to weight data at the MAC input.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle tile start; sampled only in IDLE.
- cfg_base_addr  in  WBUF_READ_ADDR_WIDTH  first weight address of the tile.
- cfg_num_addr  in  WBUF_READ_ADDR_WIDTH  addresses per pass; 0 means empty tile.
- cfg_num_pass  in  LOOP_CNT_WIDTH  number of passes over the address range; 0 means empty tile.
- stall  in  1  feeder not ready; blocks issue this cycle.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at tile completion.
- read_req_w_mem  out  1  weight-buffer read request to row-0 PEs.
- r_addr_w_mem  out  WBUF_READ_ADDR_WIDTH  weight-buffer read address.
- act_valid  out  1  activation feeder must present act_in this cycle.
- out_valid  out  1  sum_out of the last PE row (column 0) is valid.

Behaviour:
- Reset:
  - State goes to IDLE; all counters and the valid delay line clear.
  - All outputs are 0 on the cycle after reset is sampled high; r_addr_w_mem is 0.
  - Reset mid-tile aborts the tile with no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start with cfg_num_addr != 0 and cfg_num_pass != 0: latch the three cfg inputs, clear addr_cnt and pass_cnt, go to RUN.
  - On start with either count 0: go to DONE directly; no read is issued.
- RUN, issue = ~stall:
  - read_req_w_mem = issue (combinational from state and stall).
  - r_addr_w_mem = base + addr_cnt, modulo 2^WBUF_READ_ADDR_WIDTH (wraps, no saturation).
  - r_addr_w_mem holds its value while stalled.
  - On issue, addr_cnt increments. At num_addr-1 it wraps to 0 and pass_cnt increments.
  - On issue of the last address of the last pass, go to DRAIN.
  - While stalled, counters hold and read_req_w_mem = 0.
- Valid delay line, D = WBUF_READ_LATENCY_B + ARRAY_M:
  - Single-bit shift register fed by read_req_w_mem.
  - act_valid = read_req_w_mem delayed WBUF_READ_LATENCY_B cycles.
  - out_valid = read_req_w_mem delayed D cycles.
  - The line shifts every cycle in all states; it is not gated by stall.
- DRAIN:
  - Drain counter runs D cycles (cycles 0..D-1), then the FSM goes to DONE.
  - By then every issued request has produced its out_valid.
- DONE: done = 1 for exactly one cycle, then IDLE.
- busy: state != IDLE, which includes the DONE cycle.
- start while busy is ignored and has no queuing effect.
- Config inputs are don't-care except when sampled with start in IDLE.
- Simultaneous events:
  - stall on the final-issue cycle: the final issue is deferred; no DRAIN until it issues.
  - reset together with start: reset wins.

Test Plan:
1. M=4, LAT=1, base=0x10, num_addr=4, num_pass=2, no stall, start at cycle 0 -> RUN from cycle 1:
   - addresses 10,11,12,13,10,11,12,13 with read_req=1 on cycles 1-8.
   - act_valid on cycles 2-9; out_valid on cycles 6-13.
   - DRAIN on cycles 9-13; done=1 on cycle 14; busy on cycles 1-14.
2. Same as 1 with stall=1 on cycles 3-4 -> read_req=0 and r_addr_w_mem held at 0x12 on cycles 3-4; address sequence unchanged; act_valid/out_valid show matching gaps; done on cycle 16.
3. num_addr=0 (or num_pass=0), start at cycle 0 -> done=1 on cycle 1; read_req, act_valid and out_valid never assert.
4. base=0xFE, num_addr=4, num_pass=1 -> addresses FE,FF,00,01; done 6 cycles after last issue.
5. reset asserted on cycle 4 of scenario 1:
   - cycle 5: busy, read_req, act_valid and out_valid are 0; no done.
   - A fresh start on cycle 6 reproduces scenario 1 timing offset by 6.
6. start pulsed again on cycle 5 of scenario 1 -> ignored; exactly one done on cycle 14; no second tile.
